mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk input 1: single pipeline clock; all state updates on rising edge.
REQ-002 rst_n input 1: asynchronous, active-low reset.
REQ-003 if_Req input 1: fetch-stage read request, held until if_Ack; if_Addr input 32: fetch word address.
REQ-004 if_Ack output 1: one-cycle pulse; if_Rdata output 32: fetched instruction, valid while if_Ack=1.
REQ-005 m_Read input 1, m_Write input 1: MEM-stage data request, held until m_Ack; never both high.
REQ-006 m_Addr input 32, m_Wdata input 32: data address and store data.
REQ-007 m_Ack output 1: one-cycle pulse; m_Rdata output 32: load data, valid while m_Ack=1.
REQ-008 mem_Req output 1, mem_We output 1, mem_Addr output 32, mem_Wdata output 32: unified single-port memory command.
REQ-009 mem_Rdata input 32, mem_Ready input 1: memory response; transfer completes in a cycle with mem_Req=1 and mem_Ready=1.
REQ-010 flush input 1: branch taken; the in-flight or requested fetch is dead.
REQ-011 halt input 1: machine halted; no new fetch grants.
REQ-012 stall output 1: freeze pipeline registers (drives injectNop path).
REQ-013 stallCount output 16: saturating count of cycles with stall=1.

Function
REQ-014 FSM states IDLE, IF_BUSY, D_BUSY, RESP; RESP carries a registered owner flag (IF or D) and a discard flag.
REQ-015 IDLE: m_Read|m_Write -> D_BUSY (data has strict priority); else if_Req & ~halt & ~flush -> IF_BUSY; else stay IDLE.
REQ-016 Address, write data and write-enable are captured on the grant edge and held on mem_* for the entire busy state.
REQ-017 mem_Req=1 exactly in IF_BUSY and D_BUSY; mem_We=1 only in D_BUSY for a write grant.
REQ-018 Busy state with mem_Ready=1: capture mem_Rdata, go to RESP; mem_Ready=0: stay, unbounded wait.
REQ-019 RESP lasts exactly one cycle: pulse owner's ack with captured data, then IDLE; no grant is made in RESP.
REQ-020 Minimum latency: request at cycle N, mem_Req at N+1, mem_Ready at N+1, ack at N+2; next grant decided at N+3.
REQ-021 flush in IF_BUSY or RESP-owned-by-IF sets discard; a discarded response produces no if_Ack, and the memory access still completes.
REQ-022 flush has no effect on data transfers.
REQ-023 halt blocks only new fetch grants; an in-flight fetch completes normally and data requests are still served.
REQ-024 stall = (m_Read|m_Write) & ~m_Ack | if_Req & ~if_Ack & ~halt, evaluated combinationally each cycle.
REQ-025 stallCount increments when stall=1 and saturates at 16'hFFFF.
REQ-026 if_Rdata and m_Rdata hold their last captured value when not acked.

Reset
REQ-027 On rst_n=0: state IDLE, mem_Req=0, mem_We=0, if_Ack=0, m_Ack=0, discard=0, stallCount=0, mem_Addr/mem_Wdata/if_Rdata/m_Rdata=0; all asynchronous.
REQ-028 Reset mid-transfer abandons the access with no ack; after deassertion the first grant happens on the first edge with a request.

Structure
REQ-029 State encodings (2-bit) and owner codes belong in defs.v alongside the existing pipeline constants.
REQ-030 Single module, no sub-modules; stallCount saturating counter kept inline.

Verification
REQ-031 Fetch only, if_Req=1 addr 0x40, mem_Ready=1 at once -> mem_Req at cycle 1, if_Ack at cycle 2 with mem_Rdata value 0x8C010004.
REQ-032 if_Req and m_Read (addr 0x100) raised together -> data granted first, m_Ack, then fetch granted; stall=1 throughout until if_Ack.
REQ-033 Store m_Write addr 0x200 data 0xDEADBEEF, mem_Ready after 3 wait cycles -> mem_We=1 with stable addr/data for 4 cycles, m_Ack once.
REQ-034 flush pulsed during IF_BUSY with mem_Ready delayed 2 cycles -> memory access completes, no if_Ack; next fetch proceeds normally.
REQ-035 halt=1 with if_Req=1 -> no mem_Req issued, stall=0; m_Read still completes with m_Ack.
REQ-036 rst_n low during D_BUSY -> mem_Req drops immediately, no m_Ack; stallCount reads 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM state and port-owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    RESP    = 2'd3
  } arb_state_e;
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and MEM-stage data access
// Ports: clk/rst_n (async active-low); if_* fetch request/ack; m_* load/store request/ack;
// mem_* unified memory command/response; flush kills the current fetch; halt blocks new
// fetch grants; stall freezes the pipeline; stallCount saturates at 16'hFFFF.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_Req,
  input  logic [31:0] if_Addr,
  output logic        if_Ack,
  output logic [31:0] if_Rdata,
  input  logic        m_Read,
  input  logic        m_Write,
  input  logic [31:0] m_Addr,
  input  logic [31:0] m_Wdata,
  output logic        m_Ack,
  output logic [31:0] m_Rdata,
  output logic        mem_Req,
  output logic        mem_We,
  output logic [31:0] mem_Addr,
  output logic [31:0] mem_Wdata,
  input  logic [31:0] mem_Rdata,
  input  logic        mem_Ready,
  input  logic        flush,
  input  logic        halt,
  output logic        stall,
  output logic [15:0] stallCount
);
  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        discard_q, discard_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] m_rdata_q, m_rdata_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        d_req;
  logic        if_kill;
  always_comb begin
    d_req      = m_Read | m_Write;
    // a fetch is dead once flushed, including a flush arriving in the same cycle
    if_kill    = discard_q | flush;
    state_d    = state_q;
    owner_d    = owner_q;
    discard_d  = discard_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    m_rdata_d  = m_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d   = D_BUSY;
          owner_d   = OWN_D;
          discard_d = 1'b0;
          we_d      = m_Write;
          addr_d    = m_Addr;
          wdata_d   = m_Wdata;
        end else if (if_Req && !halt && !flush) begin
          state_d   = IF_BUSY;
          owner_d   = OWN_IF;
          discard_d = 1'b0;
          we_d      = 1'b0;
          addr_d    = if_Addr;
        end
      end
      IF_BUSY: begin
        discard_d = if_kill;
        if (mem_Ready) begin
          state_d    = RESP;
          if_rdata_d = if_kill ? if_rdata_q : mem_Rdata;
        end
      end
      D_BUSY: begin
        if (mem_Ready) begin
          state_d   = RESP;
          m_rdata_d = mem_Rdata;
        end
      end
      default: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    endcase
    // acks are combinational so a flush landing in RESP still suppresses the fetch ack
    if_Ack      = (state_q == RESP) && (owner_q == OWN_IF) && !if_kill;
    m_Ack       = (state_q == RESP) && (owner_q == OWN_D);
    stall       = (d_req && !m_Ack) || (if_Req && !if_Ack && !halt);
    stall_cnt_d = (stall && stall_cnt_q != STALL_MAX) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      discard_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      m_rdata_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      discard_q   <= discard_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      m_rdata_q   <= m_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign mem_Req    = (state_q == IF_BUSY) || (state_q == D_BUSY);
  assign mem_We     = (state_q == D_BUSY) && we_q;
  assign mem_Addr   = addr_q;
  assign mem_Wdata  = wdata_q;
  assign if_Rdata   = if_rdata_q;
  assign m_Rdata    = m_rdata_q;
  assign stallCount = stall_cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a memory responder and reference memory model
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_Req = 1'b0, if_Ack;
  logic [31:0] if_Addr = '0, if_Rdata;
  logic        m_Read = 1'b0, m_Write = 1'b0, m_Ack;
  logic [31:0] m_Addr = '0, m_Wdata = '0, m_Rdata;
  logic        mem_Req, mem_We;
  logic [31:0] mem_Addr, mem_Wdata;
  logic [31:0] mem_Rdata = '0;
  logic        mem_Ready = 1'b0;
  logic        flush = 1'b0, halt = 1'b0;
  logic        stall;
  logic [15:0] stallCount;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_Req(if_Req), .if_Addr(if_Addr), .if_Ack(if_Ack), .if_Rdata(if_Rdata),
    .m_Read(m_Read), .m_Write(m_Write), .m_Addr(m_Addr), .m_Wdata(m_Wdata),
    .m_Ack(m_Ack), .m_Rdata(m_Rdata),
    .mem_Req(mem_Req), .mem_We(mem_We), .mem_Addr(mem_Addr), .mem_Wdata(mem_Wdata),
    .mem_Rdata(mem_Rdata), .mem_Ready(mem_Ready),
    .flush(flush), .halt(halt), .stall(stall), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] d;
  } dexp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] fq[$];
  dexp_t       dq[$];
  logic [31:0] store[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          fixed_wait = 0;
  int          wcnt = 0;
  bit          in_xfer = 0;
  int          xfers = 0, we_cycles = 0, req_cycles = 0, iack_cnt = 0;
  int          scnt = 0;
  time         t_iack = 0, t_mack = 0;
  logic [31:0] cur_waddr = '0, cur_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C01_0004 : {a[15:0], ~a[15:0]};
  endfunction

  // memory responder: per transfer waits fixed_wait cycles (or random 0..3 when negative)
  initial forever begin
    @(posedge clk);
    #1;
    if (mem_Req) begin
      if (!in_xfer) begin
        in_xfer = 1;
        wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
      mem_Ready = (wcnt == 0);
      if (wcnt > 0) wcnt--;
      mem_Rdata = store.exists(mem_Addr) ? store[mem_Addr] : init_word(mem_Addr);
    end else begin
      in_xfer = 0;
      mem_Ready = 1'b0;
    end
  end

  // monitor: pops scoreboard entries on acks, checks store command and stall each cycle
  initial forever begin
    logic exp_stall;
    @(negedge clk);
    if (rst_n) begin
      exp_stall = ((m_Read | m_Write) & ~m_Ack) | (if_Req & ~if_Ack & ~halt);
      check("stall", 32'(stall), 32'(exp_stall));
      if (exp_stall && scnt < 65535) scnt++;
      if (mem_Req) begin
        req_cycles++;
        if (mem_We) begin
          we_cycles++;
          check("st_addr", mem_Addr, cur_waddr);
          check("st_data", mem_Wdata, cur_wdata);
        end
        if (mem_Ready) begin
          xfers++;
          if (mem_We) store[mem_Addr] = mem_Wdata;
        end
      end
      if (if_Ack) begin
        iack_cnt++;
        t_iack = $time;
        if (fq.size() == 0) check("if_ack_unexpected", 32'd1, 32'd0);
        else check("if_Rdata", if_Rdata, fq.pop_front());
      end
      if (m_Ack) begin
        t_mack = $time;
        if (dq.size() == 0) check("m_ack_unexpected", 32'd1, 32'd0);
        else begin
          dexp_t e;
          e = dq.pop_front();
          if (!e.we) check("m_Rdata", m_Rdata, e.d);
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, output int cyc);
    bit got;
    got = 0;
    cyc = 0;
    if_Req = 1'b1;
    if_Addr = a;
    fq.push_back(init_word(a));
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      cyc++;
      got = if_Ack;
    end
    if (!got) check("if_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if_Req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 0;
    m_Addr = a;
    m_Wdata = d;
    m_Write = we;
    m_Read = !we;
    if (we) begin
      cur_waddr = a;
      cur_wdata = d;
      ref_mem[a] = d;
      dq.push_back('{we: 1'b1, d: 32'h0});
    end else begin
      dq.push_back('{we: 1'b0, d: ref_mem.exists(a) ? ref_mem[a] : init_word(a)});
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = m_Ack;
    end
    if (!got) check("m_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    m_Read = 1'b0;
    m_Write = 1'b0;
  endtask

  initial begin
    int cyc, cyc2, n0, r0, ic0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_Req", 32'(mem_Req), 32'd0);
    check("rst_mem_We", 32'(mem_We), 32'd0);
    check("rst_if_Ack", 32'(if_Ack), 32'd0);
    check("rst_m_Ack", 32'(m_Ack), 32'd0);
    check("rst_stallCount", 32'(stallCount), 32'd0);
    check("rst_mem_Addr", mem_Addr, 32'd0);
    check("rst_mem_Wdata", mem_Wdata, 32'd0);
    check("rst_if_Rdata", if_Rdata, 32'd0);
    check("rst_m_Rdata", m_Rdata, 32'd0);
    scnt = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // minimum-latency fetch
    fork
      do_fetch(32'h40, cyc);
      begin
        @(negedge clk);
        check("f_req_c0", 32'(mem_Req), 32'd0);
        @(negedge clk);
        check("f_req_c1", 32'(mem_Req), 32'd1);
        check("f_addr", mem_Addr, 32'h40);
        check("f_we", 32'(mem_We), 32'd0);
      end
    join
    check("f_latency", cyc, 32'd3);
    // simultaneous data and fetch: data wins
    fork
      do_data(1'b0, 32'h100, 32'h0);
      do_fetch(32'h40, cyc2);
    join
    check("data_first", 32'(t_mack < t_iack), 32'd1);
    // store with three wait states
    fixed_wait = 3;
    we_cycles = 0;
    do_data(1'b1, 32'h200, 32'hDEAD_BEEF);
    check("st_we_cycles", we_cycles, 32'd4);
    do_data(1'b0, 32'h200, 32'h0);
    // flush during fetch busy
    fixed_wait = 2;
    n0 = xfers;
    ic0 = iack_cnt;
    if_Req = 1'b1;
    if_Addr = 32'h80;
    @(posedge clk);
    #1;
    flush = 1'b1;
    if_Req = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("flush_xfer_done", xfers - n0, 32'd1);
    check("flush_no_ack", iack_cnt - ic0, 32'd0);
    fixed_wait = 0;
    do_fetch(32'h44, cyc);
    check("post_flush_lat", cyc, 32'd3);
    // halt blocks fetch grants but not data
    halt = 1'b1;
    r0 = req_cycles;
    ic0 = iack_cnt;
    fork
      do_fetch(32'h48, cyc);
      begin
        repeat (5) @(negedge clk);
        check("halt_no_req", req_cycles - r0, 32'd0);
        check("halt_stall", 32'(stall), 32'd0);
        do_data(1'b0, 32'h104, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("halt_no_if_ack", iack_cnt - ic0, 32'd0);
        halt = 1'b0;
      end
    join
    // reset during data busy
    fixed_wait = 10;
    m_Read = 1'b1;
    m_Addr = 32'h108;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_req", 32'(mem_Req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drop_req", 32'(mem_Req), 32'd0);
    check("rst_m_ack", 32'(m_Ack), 32'd0);
    check("rst_cnt", 32'(stallCount), 32'd0);
    m_Read = 1'b0;
    scnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fixed_wait = 0;
    do_fetch(32'h4C, cyc);
    check("post_rst_lat", cyc, 32'd3);
    // randomized concurrent traffic
    fixed_wait = -1;
    fork
      for (int i = 0; i < 40; i++) begin
        int c;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        do_fetch({24'h0, 6'($urandom_range(0, 63)), 2'b00}, c);
      end
      for (int i = 0; i < 40; i++) begin
        bit we;
        logic [31:0] a;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        we = 1'($urandom_range(0, 1));
        a = (we || $urandom_range(0, 1) == 1) ? 32'h100 + {25'h0, 5'($urandom_range(0, 31)), 2'b00}
                                              : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        do_data(we, a, $urandom);
      end
      begin
        repeat (300) begin
          @(posedge clk);
          #1;
          halt = ($urandom_range(0, 4) == 0);
        end
        halt = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("stallCount", 32'(stallCount), scnt);
    check("queues_empty", fq.size() + dq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
